store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Store-side counterpart of the immediate/load extension path: narrows a 32-bit rt value to byte/halfword/word and merges it into a word-only data memory via read-modify-write.
- Sits between the execute stage's store request and a data memory that has only a 32-bit whole-word write port and a fixed-latency synchronous read.
- Handles alignment checking, lane placement (little-endian) and sequencing of the memory read/write.

Parameters:
- MEM_LAT, 1, read latency in cycles from the mem_rd cycle to the cycle mem_rdata is valid; legal range 1..4.
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request.
- req_addr  input  ADDR_W  byte address of the store.
- req_wdata  input  32  rt register value; the low bits are used for sb/sh.
- req_size  input  2  00=sb, 01=sh, 10=sw, 11=illegal.
- mem_addr  output  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}.
- mem_rd  output  1  one-cycle read strobe.
- mem_rdata  input  32  read data, valid MEM_LAT cycles after the mem_rd cycle.
- mem_we  output  1  one-cycle whole-word write strobe.
- mem_wdata  output  32  merged word to write.
- be  output  4  byte lanes modified by the current store; debug/trace only.
- done  output  1  one-cycle pulse: store committed.
- err  output  1  one-cycle pulse: misaligned or illegal request; no memory access.

Behaviour:
- Reset:
  - Asynchronous; forces state IDLE, latency counter 0, captured registers 0.
  - All outputs are 0 while reset is high, including req_ready.
  - Reset mid-operation abandons the store and issues no mem_we.
- Handshake:
  - req_ready = (state==IDLE) && !reset.
  - A request is accepted on the rising edge where req_valid && req_ready.
  - addr, wdata and size are captured at accept; later input changes are ignored.
- Error check at accept:
  - size 11 is an error.
  - sh with addr[0]=1 is an error.
  - sw with addr[1:0]!=0 is an error.
  - On error, go to ERR: err=1 for one cycle, no mem_rd/mem_we, then IDLE.
- States: IDLE, RD, WAIT, WR, DONE, ERR.
- sw: IDLE -> WR -> DONE -> IDLE.
  - mem_we is high in the first cycle after accept; mem_wdata = wdata, be=1111.
  - done is high in the following cycle.
- sb/sh: IDLE -> RD -> WAIT -> WR -> DONE -> IDLE.
  - RD: mem_rd=1 for exactly one cycle.
  - WAIT: lasts MEM_LAT cycles; mem_rdata is sampled at the end of the last WAIT cycle.
  - WR: mem_we=1 with the merged word.
  - DONE: done=1.
  - With MEM_LAT=1, the access is 4 cycles from accept to done.
- mem_addr holds stable from RD through WR; it is 0 in IDLE.
- Lane placement, with o = addr[1:0]:
  - sb: byte lane o = wdata[7:0], be = 1<<o; other lanes are copied from mem_rdata.
  - sh: addr[1]=0 -> bits[15:0] = wdata[15:0], be=0011; addr[1]=1 -> bits[31:16] = wdata[15:0], be=1100.
- be is valid only while mem_we=1; otherwise 0.
- done and err are never high in the same cycle. mem_rd and mem_we are never high in the same cycle.
- Back-to-back: req_ready returns high the cycle after DONE/ERR, so the minimum spacing between accepts is 3 cycles for sw.

Test Plan:
- Reset, then sw addr=0x10, wdata=0xDEADBEEF -> mem_we one cycle after accept, mem_addr=0x10, mem_wdata=0xDEADBEEF, be=1111, no mem_rd, done on the next cycle.
- sb addr=0x23, wdata=0x000000AB, memory word 0x11223344, MEM_LAT=1 -> mem_rd at mem_addr=0x20, mem_wdata=0xAB223344, be=1000, done 4 cycles after accept.
- sh addr=0x42, wdata=0xFFFF5566, memory word 0x11223344 -> mem_wdata=0x55663344, be=1100. Repeat with addr=0x40 -> mem_wdata=0x11225566, be=0011.
- Misaligned sh addr=0x41, sw addr=0x42, and size=11 -> err pulse 1 cycle after accept each time, mem_rd=mem_we=0 throughout, req_ready high the next cycle.
- MEM_LAT=3, sb addr=0x01 -> exactly 3 WAIT cycles, the data presented in the third WAIT cycle is the data merged; req_addr/req_wdata toggled after accept have no effect.
- Assert reset during WAIT of an sb -> all outputs 0 immediately, no mem_we ever issued; after release, req_ready=1 and a new sw completes normally.

Source files
------------

// File: rtl/store_merge_unit_if.sv
// Store request and word-memory bus bundle for store_merge_unit.
// The slave modport is the unit's view; master is the requester/memory side.
interface store_merge_unit_if #(
    parameter int ADDR_W = 32
);
    // Store request from the execute stage
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;

    // Word-only data memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    // Status / trace
    logic [3:0]        be;
    logic              done;
    logic              err;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_size, mem_rdata,
        output req_ready, mem_addr, mem_rd, mem_we, mem_wdata, be, done, err
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_size, mem_rdata,
        input  req_ready, mem_addr, mem_rd, mem_we, mem_wdata, be, done, err
    );
endinterface

// File: rtl/store_merge_unit.sv
// Store merge unit: narrows rt to byte/halfword/word and commits it to a
// word-only memory. Word stores write directly; sub-word stores do a
// read-modify-write with a fixed memory read latency of MEM_LAT cycles.
module store_merge_unit #(
    parameter int MEM_LAT = 1,   // 1..4
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    store_merge_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Last value of the wait counter; WAIT spans MEM_LAT cycles.
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t            state_q;
    logic [1:0]        lat_cnt_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              mem_we_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        be_q;
    logic              done_q;
    logic              err_q;

    logic              req_bad;
    logic [ADDR_W-1:0] req_word_addr;
    logic [3:0]        lanes_d;
    logic [31:0]       merged_d;

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    lane_mask = 4'b0001 << off;
            SZ_H:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Replicate the store data across lanes, then take each enabled lane from
    // it and every other lane from the old memory word (little-endian).
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [3:0]  lanes);
        logic [31:0] placed;
        case (size)
            SZ_B:    placed = {4{wdata[7:0]}};
            SZ_H:    placed = {2{wdata[15:0]}};
            default: placed = wdata;
        endcase
        for (int i = 0; i < 4; i++) begin
            merge_word[8*i +: 8] = lanes[i] ? placed[8*i +: 8] : old_word[8*i +: 8];
        end
    endfunction

    // Request decode and merge datapath from captured fields.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_bad       = 1'b0;
        req_word_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
        case (bus.req_size)
            SZ_H:    req_bad = bus.req_addr[0];
            SZ_W:    req_bad = (bus.req_addr[1:0] != 2'b00);
            SZ_B:    req_bad = 1'b0;
            default: req_bad = 1'b1;
        endcase
        lanes_d  = lane_mask(size_q, off_q);
        merged_d = merge_word(bus.mem_rdata, wdata_q, size_q, lanes_d);
    end

    // Sequencing FSM with registered strobes; pulses default low each cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= '0;
            off_q       <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            be_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            mem_rd_q <= 1'b0;
            mem_we_q <= 1'b0;
            be_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        off_q   <= bus.req_addr[1:0];
                        size_q  <= bus.req_size;
                        wdata_q <= bus.req_wdata;
                        if (req_bad) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (bus.req_size == SZ_W) begin
                            // Whole word: no read needed, write straight away.
                            state_q     <= S_WR;
                            mem_addr_q  <= req_word_addr;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= bus.req_wdata;
                            be_q        <= 4'b1111;
                        end else begin
                            state_q    <= S_RD;
                            mem_addr_q <= req_word_addr;
                            mem_rd_q   <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state_q   <= S_WAIT;
                    lat_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        // Read data is valid in this last WAIT cycle.
                        state_q     <= S_WR;
                        lat_cnt_q   <= '0;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged_d;
                        be_q        <= lanes_d;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 2'd1;
                    end
                end
                S_WR: begin
                    state_q     <= S_DONE;
                    done_q      <= 1'b1;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && !reset;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.be        = be_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: a vector table run on a MEM_LAT=1
// instance, one vector on a MEM_LAT=3 instance, and a mid-store reset.
module tb_store_merge_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    store_merge_unit_if #(.ADDR_W(32)) bus1 ();
    store_merge_unit_if #(.ADDR_W(32)) bus3 ();

    store_merge_unit #(.MEM_LAT(1), .ADDR_W(32)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    store_merge_unit #(.MEM_LAT(3), .ADDR_W(32)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          bad;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    typedef struct packed {
        logic        ready;
        logic        rd;
        logic        we;
        logic        done;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } obs_t;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic obs_t sample(input bit use3);
        obs_t o;
        if (use3) begin
            o = '{bus3.req_ready, bus3.mem_rd, bus3.mem_we, bus3.done, bus3.err,
                  bus3.mem_addr, bus3.mem_wdata, bus3.be};
        end else begin
            o = '{bus1.req_ready, bus1.mem_rd, bus1.mem_we, bus1.done, bus1.err,
                  bus1.mem_addr, bus1.mem_wdata, bus1.be};
        end
        return o;
    endfunction

    task automatic drive(input bit use3, input logic valid, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size);
        if (use3) begin
            bus3.req_valid = valid; bus3.req_addr = addr;
            bus3.req_wdata = wdata; bus3.req_size = size;
        end else begin
            bus1.req_valid = valid; bus1.req_addr = addr;
            bus1.req_wdata = wdata; bus1.req_size = size;
        end
    endtask

    task automatic set_rdata(input bit use3, input logic [31:0] d);
        if (use3) bus3.mem_rdata = d;
        else      bus1.mem_rdata = d;
    endtask

    task automatic check_all_zero(input string tag, input obs_t o);
        check({tag, "_ready"}, 32'(o.ready), 32'd0);
        check({tag, "_mem_rd"}, 32'(o.rd), 32'd0);
        check({tag, "_mem_we"}, 32'(o.we), 32'd0);
        check({tag, "_done"}, 32'(o.done), 32'd0);
        check({tag, "_err"}, 32'(o.err), 32'd0);
        check({tag, "_mem_addr"}, o.addr, 32'd0);
        check({tag, "_mem_wdata"}, o.wdata, 32'd0);
        check({tag, "_be"}, 32'(o.be), 32'd0);
    endtask

    // Issue one request, present read data only in the cycle it is valid,
    // scramble the request inputs after accept, and check the whole timeline.
    // Called #1 after a rising edge with the unit idle; returns the same way.
    task automatic run_vec(input vec_t v, input bit use3, input int lat, input string tag);
        obs_t        o;
        int          rd_cyc = -1, rd_cnt = 0, we_cyc = -1, we_cnt = 0;
        int          done_cyc = -1, done_cnt = 0, err_cyc = -1, err_cnt = 0;
        int          ready_cyc = -1, clash = 0;
        int          e_rd, e_we, e_done, e_err, e_ready;
        logic [31:0] rd_addr = '0, we_addr = '0, we_data = '0, idle_addr = '1;
        logic [3:0]  we_be = '0;

        o = sample(use3);
        check({tag, "_ready_idle"}, 32'(o.ready), 32'd1);
        drive(use3, 1'b1, v.addr, v.wdata, v.size);
        set_rdata(use3, 32'hBAD0BAD0);
        @(posedge clk); #1;
        drive(use3, 1'b0, ~v.addr, ~v.wdata, 2'b11);

        for (int cyc = 1; cyc <= 16 && ready_cyc < 0; cyc++) begin
            set_rdata(use3, (cyc == 1 + lat) ? v.rdata : {4{8'hB0 | 8'(cyc)}});
            o = sample(use3);
            if (o.rd) begin
                rd_cnt++;
                if (rd_cyc < 0) begin rd_cyc = cyc; rd_addr = o.addr; end
            end
            if (o.we) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc = cyc; we_addr = o.addr; we_data = o.wdata; we_be = o.be;
                end
            end
            if (o.done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (o.err)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = cyc;  end
            if ((o.rd && o.we) || (o.done && o.err) || (!o.we && o.be != 4'b0000)) clash++;
            if (o.ready) begin
                ready_cyc = cyc;
                idle_addr = o.addr;
            end else begin
                @(posedge clk); #1;
            end
        end

        if (v.bad) begin
            e_rd = -1; e_we = -1; e_done = -1; e_err = 1; e_ready = 2;
        end else if (v.size == 2'b10) begin
            e_rd = -1; e_we = 1; e_done = 2; e_err = -1; e_ready = 3;
        end else begin
            e_rd = 1; e_we = 2 + lat; e_done = 3 + lat; e_err = -1; e_ready = 4 + lat;
        end

        check({tag, "_rd_cycle"},    32'(rd_cyc),    32'(e_rd));
        check({tag, "_rd_count"},    32'(rd_cnt),    (e_rd > 0) ? 32'd1 : 32'd0);
        check({tag, "_we_cycle"},    32'(we_cyc),    32'(e_we));
        check({tag, "_we_count"},    32'(we_cnt),    (e_we > 0) ? 32'd1 : 32'd0);
        check({tag, "_done_cycle"},  32'(done_cyc),  32'(e_done));
        check({tag, "_done_count"},  32'(done_cnt),  (e_done > 0) ? 32'd1 : 32'd0);
        check({tag, "_err_cycle"},   32'(err_cyc),   32'(e_err));
        check({tag, "_err_count"},   32'(err_cnt),   (e_err > 0) ? 32'd1 : 32'd0);
        check({tag, "_ready_cycle"}, 32'(ready_cyc), 32'(e_ready));
        check({tag, "_clash"},       32'(clash),     32'd0);
        check({tag, "_idle_addr"},   idle_addr,      32'd0);
        if (e_rd > 0) check({tag, "_rd_addr"}, rd_addr, v.exp_addr);
        if (e_we > 0) begin
            check({tag, "_we_addr"},  we_addr,     v.exp_addr);
            check({tag, "_we_wdata"}, we_data,     v.exp_wdata);
            check({tag, "_we_be"},    32'(we_be),  32'(v.exp_be));
        end
    endtask

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        vec_t v;
        logic we_seen, done_seen;

        //           size   addr          wdata         rdata         bad   exp_addr      exp_wdata     be
        vecs[0]  = '{2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111};
        vecs[1]  = '{2'b00, 32'h0000_0023, 32'h0000_00AB, 32'h1122_3344, 1'b0, 32'h0000_0020, 32'hAB22_3344, 4'b1000};
        vecs[2]  = '{2'b01, 32'h0000_0042, 32'hFFFF_5566, 32'h1122_3344, 1'b0, 32'h0000_0040, 32'h5566_3344, 4'b1100};
        vecs[3]  = '{2'b01, 32'h0000_0040, 32'hFFFF_5566, 32'h1122_3344, 1'b0, 32'h0000_0040, 32'h1122_5566, 4'b0011};
        vecs[4]  = '{2'b00, 32'h0000_0001, 32'h1234_5678, 32'h1122_3344, 1'b0, 32'h0000_0000, 32'h1122_7844, 4'b0010};
        vecs[5]  = '{2'b00, 32'h0000_0002, 32'h0000_0099, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 32'hCA99_F00D, 4'b0100};
        vecs[6]  = '{2'b00, 32'h0000_0030, 32'h0000_00CD, 32'h1122_3344, 1'b0, 32'h0000_0030, 32'h1122_33CD, 4'b0001};
        vecs[7]  = '{2'b01, 32'h0000_0041, 32'h0000_1234, 32'h1122_3344, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000};
        vecs[8]  = '{2'b10, 32'h0000_0042, 32'h0000_1234, 32'h1122_3344, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000};
        vecs[9]  = '{2'b11, 32'h0000_0050, 32'h0000_1234, 32'h1122_3344, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000};
        vecs[10] = '{2'b10, 32'h0000_0044, 32'h0102_0304, 32'h0000_0000, 1'b0, 32'h0000_0044, 32'h0102_0304, 4'b1111};
        vecs[11] = '{2'b01, 32'h0000_0043, 32'h0000_ABCD, 32'h1122_3344, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0000};

        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 2'b00);
        drive(1'b1, 1'b0, '0, '0, 2'b00);
        set_rdata(1'b0, '0);
        set_rdata(1'b1, '0);
        #1;
        check_all_zero("reset1", sample(1'b0));
        check_all_zero("reset3", sample(1'b1));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        o = sample(1'b0);
        check("post_reset_ready1", 32'(o.ready), 32'd1);
        o = sample(1'b1);
        check("post_reset_ready3", 32'(o.ready), 32'd1);

        // Table on the MEM_LAT=1 instance, back-to-back at minimum spacing.
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], 1'b0, 1, $sformatf("v%0d", i));
        end

        // MEM_LAT=3: only the third WAIT cycle carries the real word.
        v = '{2'b00, 32'h0000_0001, 32'h0000_00EE, 32'hA1B2_C3D4, 1'b0, 32'h0000_0000, 32'hA1B2_EED4, 4'b0010};
        run_vec(v, 1'b1, 3, "lat3_sb");

        // Reset asserted during WAIT of a byte store.
        drive(1'b0, 1'b1, 32'h0000_0003, 32'h0000_0077, 2'b00);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 2'b00);
        o = sample(1'b0);
        check("mid_rst_rd_seen", 32'(o.rd), 32'd1);
        @(posedge clk); #1;
        set_rdata(1'b0, 32'h5555_5555);
        reset = 1'b1;
        #1;
        check_all_zero("mid_rst", sample(1'b0));
        we_seen   = 1'b0;
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            o = sample(1'b0);
            we_seen   |= o.we;
            done_seen |= o.done;
        end
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            o = sample(1'b0);
            we_seen   |= o.we;
            done_seen |= o.done;
        end
        check("mid_rst_no_we", 32'(we_seen), 32'd0);
        check("mid_rst_no_done", 32'(done_seen), 32'd0);
        o = sample(1'b0);
        check("mid_rst_ready_after", 32'(o.ready), 32'd1);
        v = '{2'b10, 32'h0000_0080, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 32'h0000_0080, 32'h0BAD_F00D, 4'b1111};
        run_vec(v, 1'b0, 1, "after_rst_sw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
